// File: rtl/maxpool2x2_engine_if.sv
// Control and RAM-port bundle for maxpool2x2_engine.
// master is the engine side (it drives both RAM ports); slave is the controller/RAM side.
interface maxpool2x2_engine_if;
   logic        start;
   logic [31:0] src_base;
   logic [31:0] dst_base;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic [7:0]  rd_data;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;

   modport master (
      input  start, src_base, dst_base, rd_data,
      output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, src_base, dst_base, rd_data,
      input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/maxpool2x2_engine.sv
// 2x2 stride-2 max pooling over an 8-bit map in a source RAM, results to a destination RAM.
// Each window takes six cycles: four reads, one trailing compare, one write.
module maxpool2x2_engine #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter bit SIGNED = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   maxpool2x2_engine_if.master bus
);
   localparam int OW = IMG_W / 2;
   localparam int OH = IMG_H / 2;
   localparam int CW = $clog2(((OW > OH) ? OW : OH) + 1);
   localparam logic [CW-1:0] OX_LAST = CW'(OW - 1);
   localparam logic [CW-1:0] OY_LAST = CW'(OH - 1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_WRITE, S_DONE} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    k_reg, k_next;
   logic [CW-1:0] ox_reg, ox_next;
   logic [CW-1:0] oy_reg, oy_next;
   logic [31:0]   src_reg, src_next;
   logic [31:0]   dst_reg, dst_next;
   logic [7:0]    max_reg, max_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          rd_en_reg, rd_en_next;
   logic [31:0]   rd_addr_reg, rd_addr_next;
   logic          wr_en_reg, wr_en_next;
   logic [31:0]   wr_addr_reg, wr_addr_next;
   logic [7:0]    wr_data_reg, wr_data_next;

   // k[1] selects the window row, k[0] the column; all arithmetic wraps mod 2^32.
   function automatic logic [31:0] src_addr(input logic [31:0] base, input logic [CW-1:0] ox,
                                            input logic [CW-1:0] oy, input logic [1:0] k);
      logic [31:0] row;
      logic [31:0] col;
      row = 32'(oy) * 32'd2 + {31'd0, k[1]};
      col = 32'(ox) * 32'd2 + {31'd0, k[0]};
      return base + row * 32'(IMG_W) + col;
   endfunction

   // Strictly greater, so a tie keeps the value already held.
   function automatic logic beats(input logic [7:0] a, input logic [7:0] b);
      if (SIGNED)
         return $signed(a) > $signed(b);
      return a > b;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         k_reg       <= '0;
         ox_reg      <= '0;
         oy_reg      <= '0;
         src_reg     <= '0;
         dst_reg     <= '0;
         max_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         rd_en_reg   <= 1'b0;
         rd_addr_reg <= '0;
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         k_reg       <= k_next;
         ox_reg      <= ox_next;
         oy_reg      <= oy_next;
         src_reg     <= src_next;
         dst_reg     <= dst_next;
         max_reg     <= max_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         rd_en_reg   <= rd_en_next;
         rd_addr_reg <= rd_addr_next;
         wr_en_reg   <= wr_en_next;
         wr_addr_reg <= wr_addr_next;
         wr_data_reg <= wr_data_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      k_next       = k_reg;
      ox_next      = ox_reg;
      oy_next      = oy_reg;
      src_next     = src_reg;
      dst_next     = dst_reg;
      max_next     = max_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      rd_en_next   = 1'b0;
      rd_addr_next = rd_addr_reg;
      wr_en_next   = 1'b0;
      wr_addr_next = wr_addr_reg;
      wr_data_next = wr_data_reg;

      // RAM data lags the read by one cycle: READ k=1 sees pixel 0, LAST sees pixel 3.
      if (state_reg == S_READ && k_reg == 2'd1) begin
         max_next = bus.rd_data;
      end else if ((state_reg == S_READ && k_reg[1]) || state_reg == S_LAST) begin
         if (beats(bus.rd_data, max_reg))
            max_next = bus.rd_data;
      end

      case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               state_next   = S_READ;
               k_next       = 2'd0;
               ox_next      = '0;
               oy_next      = '0;
               src_next     = bus.src_base;
               dst_next     = bus.dst_base;
               busy_next    = 1'b1;
               rd_en_next   = 1'b1;
               rd_addr_next = src_addr(bus.src_base, '0, '0, 2'd0);
            end
         end
         S_READ: begin
            if (k_reg == 2'd3) begin
               state_next = S_LAST;
            end else begin
               k_next       = k_reg + 2'd1;
               rd_en_next   = 1'b1;
               rd_addr_next = src_addr(src_reg, ox_reg, oy_reg, k_reg + 2'd1);
            end
         end
         S_LAST: begin
            state_next   = S_WRITE;
            wr_en_next   = 1'b1;
            wr_addr_next = dst_reg + 32'(oy_reg) * 32'(OW) + 32'(ox_reg);
            wr_data_next = max_next;
         end
         S_WRITE: begin
            if (ox_reg == OX_LAST && oy_reg == OY_LAST) begin
               state_next = S_DONE;
               done_next  = 1'b1;
               busy_next  = 1'b0;
            end else begin
               if (ox_reg == OX_LAST) begin
                  ox_next = '0;
                  oy_next = oy_reg + 1'b1;
               end else begin
                  ox_next = ox_reg + 1'b1;
               end
               state_next   = S_READ;
               k_next       = 2'd0;
               rd_en_next   = 1'b1;
               rd_addr_next = src_addr(src_reg, ox_next, oy_next, 2'd0);
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.rd_en   = rd_en_reg;
   assign bus.rd_addr = rd_addr_reg;
   assign bus.wr_en   = wr_en_reg;
   assign bus.wr_addr = wr_addr_reg;
   assign bus.wr_data = wr_data_reg;
endmodule

// File: tb/tb_maxpool2x2_engine.sv
// Scoreboard bench for maxpool2x2_engine: four configurations share one source map; expected
// writes and done pulses are queued before each pass and a monitor retires them as they appear.
module tb_maxpool2x2_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   logic [7:0]  src_mem [256];
   logic [3:0]  start_v = '0;
   logic [31:0] src_base_v = '0;
   logic [31:0] dst_base_v = '0;
   logic [3:0]  busy_v, done_v, rd_en_v, wr_en_v;
   logic [31:0] rd_addr_v [4];
   logic [31:0] wr_addr_v [4];
   logic [7:0]  wr_data_v [4];

   typedef struct {
      int          id;
      int          kind;   // 0 = write, 1 = done pulse
      logic [31:0] addr;
      logic [7:0]  data;
      int          at;
   } ev_t;

   ev_t         exp_q[$];
   logic [31:0] rd_log_c[$];
   logic [31:0] rd_log_d[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 0: 4x4 unsigned, 1: 4x4 signed, 2: 8x8 unsigned, 3: 5x3 unsigned
   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int IW = (gi == 2) ? 8 : (gi == 3) ? 5 : 4;
      localparam int IH = (gi == 2) ? 8 : (gi == 3) ? 3 : 4;

      maxpool2x2_engine_if bus ();

      maxpool2x2_engine #(.IMG_W(IW), .IMG_H(IH), .SIGNED(gi == 1)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      assign bus.start     = start_v[gi];
      assign bus.src_base  = src_base_v;
      assign bus.dst_base  = dst_base_v;
      assign busy_v[gi]    = bus.busy;
      assign done_v[gi]    = bus.done;
      assign rd_en_v[gi]   = bus.rd_en;
      assign wr_en_v[gi]   = bus.wr_en;
      assign rd_addr_v[gi] = bus.rd_addr;
      assign wr_addr_v[gi] = bus.wr_addr;
      assign wr_data_v[gi] = bus.wr_data;

      always @(posedge clk)
         if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr[7:0]];
   end

   always @(negedge clk) begin : monitor
      ev_t got;
      ev_t want;
      if (rd_en_v[2]) rd_log_c.push_back(rd_addr_v[2]);
      if (rd_en_v[3]) rd_log_d.push_back(rd_addr_v[3]);
      for (int i = 0; i < 4; i++) begin
         if (wr_en_v[i] || done_v[i]) begin
            got.id   = i;
            got.kind = wr_en_v[i] ? 0 : 1;
            got.addr = wr_en_v[i] ? wr_addr_v[i] : 32'd0;
            got.data = wr_en_v[i] ? wr_data_v[i] : 8'd0;
            got.at   = cyc;
            $display("[TB] inst %0d %s addr %0d data %02h cycle %0d", i,
                     got.kind == 0 ? "write" : "done ", got.addr, got.data, got.at);
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_event: inst %0d kind %0d addr %0d data %02h cycle %0d, required no event",
                        got.id, got.kind, got.addr, got.data, got.at);
            end else begin
               want = exp_q.pop_front();
               if (got.id != want.id || got.kind != want.kind || got.addr != want.addr ||
                   got.data != want.data || got.at != want.at) begin
                  fails++;
                  $display("FAIL event: got inst %0d kind %0d addr %0d data %02h cycle %0d, required inst %0d kind %0d addr %0d data %02h cycle %0d",
                           got.id, got.kind, got.addr, got.data, got.at,
                           want.id, want.kind, want.addr, want.data, want.at);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_ev(input int id, input int kind, input logic [31:0] a, input logic [7:0] d,
                          input int at);
      ev_t e;
      e.id   = id;
      e.kind = kind;
      e.addr = a;
      e.data = d;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   // Four windows of a 4x4 pass; vals holds the pooled bytes, window 0 in the top byte.
   task automatic push_4x4(input int id, input int c0, input logic [31:0] dst, input logic [31:0] vals);
      for (int n = 0; n < 4; n++)
         push_ev(id, 0, dst + 32'(n), vals[31 - 8*n -: 8], c0 + 6 * (n + 1));
      push_ev(id, 1, 32'd0, 8'd0, c0 + 25);
   endtask

   // Bases are scrambled after acceptance so only the latched copies can be correct.
   task automatic start_pass(input int id, input logic [31:0] src, input logic [31:0] dst);
      src_base_v  = src;
      dst_base_v  = dst;
      start_v[id] = 1'b1;
      @(negedge clk);
      start_v[id] = 1'b0;
      src_base_v  = 32'hDEAD_0000;
      dst_base_v  = 32'hBEEF_0000;
   endtask

   task automatic wait_done(input int id, input int budget);
      int n;
      n = 0;
      while (!done_v[id] && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_within_budget", 32'(done_v[id]), 32'd1);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int c0;
      int bad;
      logic [31:0] a;
      logic [31:0] req_c [4];
      req_c[0] = 32'd18;
      req_c[1] = 32'd19;
      req_c[2] = 32'd26;
      req_c[3] = 32'd27;
      for (int i = 0; i < 256; i++) src_mem[i] = 8'(i);

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_v), 32'd0);
      check("rst_done", 32'(done_v), 32'd0);
      check("rst_rd_en", 32'(rd_en_v), 32'd0);
      check("rst_wr_en", 32'(wr_en_v), 32'd0);
      check("rst_rd_addr", rd_addr_v[0], 32'd0);
      check("rst_wr_addr", wr_addr_v[0], 32'd0);
      check("rst_wr_data", 32'(wr_data_v[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 4x4 ramp map: writes 5,7,13,15 to 100..103, done on cycle 25
      c0 = cyc;
      push_4x4(0, c0, 32'd100, 32'h05070D0F);
      start_pass(0, 32'd0, 32'd100);
      check("c1_busy_cycle1", 32'(busy_v[0]), 32'd1);
      check("c1_rd_en_cycle1", 32'(rd_en_v[0]), 32'd1);
      check("c1_rd_addr_cycle1", rd_addr_v[0], 32'd0);
      wait_done(0, 40);
      check("c1_idle_after_done", 32'({busy_v[0], done_v[0]}), 32'd0);

      // start pulsed mid-pass is ignored
      c0 = cyc;
      push_4x4(0, c0, 32'd100, 32'h05070D0F);
      start_pass(0, 32'd0, 32'd100);
      repeat (9) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0, 40);

      // start held high: second pass accepted on the first IDLE cycle
      c0 = cyc;
      push_4x4(0, c0, 32'd100, 32'h05070D0F);
      push_4x4(0, c0 + 26, 32'd100, 32'h05070D0F);
      src_base_v = 32'd0;
      dst_base_v = 32'd100;
      start_v[0] = 1'b1;
      repeat (26) @(negedge clk);
      check("c5_idle_between_passes", 32'(busy_v[0]), 32'd0);
      @(negedge clk);
      check("c5_second_read", 32'({rd_en_v[0], busy_v[0]}), 32'd3);
      start_v[0] = 1'b0;
      wait_done(0, 40);

      // reset during the first write: pass abandoned, no done
      c0 = cyc;
      push_ev(0, 0, 32'd100, 8'd5, c0 + 6);
      start_pass(0, 32'd0, 32'd100);
      repeat (5) @(negedge clk);
      check("c6_wr_en_in_write", 32'(wr_en_v[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("c6_wr_en_after_rst", 32'(wr_en_v[0]), 32'd0);
      check("c6_busy_after_rst", 32'(busy_v[0]), 32'd0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      c0 = cyc;
      push_4x4(0, c0, 32'd100, 32'h05070D0F);
      start_pass(0, 32'd0, 32'd100);
      wait_done(0, 40);

      // signed vs unsigned compare, map placed at base 32
      for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
      src_mem[32] = 8'h80; src_mem[33] = 8'h01; src_mem[36] = 8'h7F; src_mem[37] = 8'hFE;
      src_mem[34] = 8'hFF; src_mem[35] = 8'hFF; src_mem[38] = 8'h80; src_mem[39] = 8'h90;
      src_mem[42] = 8'h10; src_mem[43] = 8'hF0; src_mem[46] = 8'h20; src_mem[47] = 8'h05;
      c0 = cyc;
      push_4x4(1, c0, 32'd200, 32'h7FFF0020);
      start_pass(1, 32'd32, 32'd200);
      wait_done(1, 40);
      c0 = cyc;
      push_4x4(0, c0, 32'd200, 32'hFEFF00F0);
      start_pass(0, 32'd32, 32'd200);
      wait_done(0, 40);

      // 8x8 ramp: window n pools to its bottom-right pixel
      for (int i = 0; i < 256; i++) src_mem[i] = 8'(i);
      rd_log_c.delete();
      c0 = cyc;
      for (int n = 0; n < 16; n++)
         push_ev(2, 0, 32'd50 + 32'(n), 8'(16 * (n / 4) + 2 * (n % 4) + 9), c0 + 6 * (n + 1));
      push_ev(2, 1, 32'd0, 8'd0, c0 + 97);
      start_pass(2, 32'd0, 32'd50);
      wait_done(2, 120);
      check("c3_read_count", 32'(rd_log_c.size()), 32'd64);
      for (int j = 0; j < 4; j++) begin
         a = (rd_log_c.size() > 20 + j) ? rd_log_c[20 + j] : 32'hFFFF_FFFF;
         check("c3_window5_rd_addr", a, req_c[j]);
      end

      // 5x3 map: odd column and row never touched
      rd_log_d.delete();
      c0 = cyc;
      push_ev(3, 0, 32'd30, 8'd6, c0 + 6);
      push_ev(3, 0, 32'd31, 8'd8, c0 + 12);
      push_ev(3, 1, 32'd0, 8'd0, c0 + 13);
      start_pass(3, 32'd0, 32'd30);
      wait_done(3, 40);
      check("c4_read_count", 32'(rd_log_d.size()), 32'd8);
      bad = 0;
      foreach (rd_log_d[j])
         if (rd_log_d[j] % 5 == 4 || rd_log_d[j] / 5 >= 2) bad++;
      check("c4_out_of_map_reads", 32'(bad), 32'd0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
